vga_dither_out: RTL and testbench

- Output stage directly downstream of the pattern controller.
- Consumes blanked 8-bit RGB plus sync/blank strobes and pixel position; registers everything through a fixed-latency pipeline so syncs stay aligned with pixels.
- Produces full-width delayed RGB for the DAC, plus ordered-dithered OUT_BITS-per-channel RGB for the digital pins that replace plain bit-slicing of r[7:6] etc.
- Sits between the controller and the top-level pin assignments.

---
 rtl/vga_out_pkg.sv | 16 +
 rtl/vga_delay_line.sv | 23 ++
 rtl/vga_dither_out.sv | 88 ++++++++
 tb/tb_vga_dither_out.sv | 116 +++++++++++
 4 files changed

// File: rtl/vga_out_pkg.sv
// vga_out_pkg: shared Bayer matrix, latency limits and colour type for the VGA output stage
package vga_out_pkg;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;
  localparam logic [0:3][0:3][3:0] BAYER4 = {
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register that loads RESET_VALUE on synchronous reset
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [DEPTH];
  // Shift one stage per clock; reset flushes every stage at once
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VALUE;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/vga_dither_out.sv
// vga_dither_out: fixed-latency VGA output stage with ordered dither; VGA_DITHER_TEMPORAL_EN rotates the pattern per frame
module vga_dither_out
  import vga_out_pkg::*;
#(
  parameter int   LATENCY          = 2,
  parameter int   OUT_BITS         = 2,
  parameter logic SYNC_RESET_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_hsync,
  input  logic                in_vsync,
  input  logic                in_hblank,
  input  logic                in_vblank,
  input  logic [1:0]          in_hpos,
  input  logic [1:0]          in_vpos,
  input  logic [7:0]          in_r,
  input  logic [7:0]          in_g,
  input  logic [7:0]          in_b,
  input  logic                dither_en,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                out_hblank,
  output logic                out_vblank,
  output logic [7:0]          out_r,
  output logic [7:0]          out_g,
  output logic [7:0]          out_b,
  output logic [OUT_BITS-1:0] out_rd,
  output logic [OUT_BITS-1:0] out_gd,
  output logic [OUT_BITS-1:0] out_bd
);
  localparam int CW = $bits(rgb8_t) + 3 * OUT_BITS;
  logic [1:0] hi, vi;
`ifdef VGA_DITHER_TEMPORAL_EN
  logic [1:0] fcnt;
  logic       vblank_q;
  // Advance the frame counter on each rising vblank so the pattern shifts diagonally per frame
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt     <= '0;
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= in_vblank;
      fcnt     <= fcnt + 2'(in_vblank & ~vblank_q);
    end
  end
  assign hi = in_hpos + fcnt;
  assign vi = in_vpos + fcnt;
`else
  assign hi = in_hpos;
  assign vi = in_vpos;
`endif
  logic [7:0] t;
  assign t = dither_en ? 8'(BAYER4[vi][hi]) << (4 - OUT_BITS) : 8'd0;
  // Add threshold with saturation at 255 so bright pixels never wrap to dark
  function automatic logic [OUT_BITS-1:0] quant(input logic [7:0] c, input logic [7:0] th);
    logic [8:0] s;
    logic [7:0] sat;
    s   = {1'b0, c} + {1'b0, th};
    sat = s[8] ? 8'hFF : s[7:0];
    return sat[7 -: OUT_BITS];
  endfunction
  rgb8_t                 pix, po;
  logic [CW-1:0]         cq;
  logic [3:0]            sq;
  logic [OUT_BITS-1:0]   prd, pgd, pbd;
  logic                  blank;
  assign pix = {in_r, in_g, in_b};
  vga_delay_line #(.WIDTH(4), .DEPTH(LATENCY), .RESET_VALUE({SYNC_RESET_LEVEL, SYNC_RESET_LEVEL, 2'b00})) u_sync (
    .clk(clk), .reset(reset),
    .d({in_hsync, in_vsync, in_hblank, in_vblank}),
    .q(sq)
  );
  vga_delay_line #(.WIDTH(CW), .DEPTH(LATENCY), .RESET_VALUE('0)) u_col (
    .clk(clk), .reset(reset),
    .d({pix, quant(in_r, t), quant(in_g, t), quant(in_b, t)}),
    .q(cq)
  );
  assign {out_hsync, out_vsync, out_hblank, out_vblank} = sq;
  assign {po, prd, pgd, pbd} = cq;
  assign blank  = out_hblank | out_vblank;
  assign out_r  = blank ? 8'd0 : po.r;
  assign out_g  = blank ? 8'd0 : po.g;
  assign out_b  = blank ? 8'd0 : po.b;
  assign out_rd = blank ? '0 : prd;
  assign out_gd = blank ? '0 : pgd;
  assign out_bd = blank ? '0 : pbd;
endmodule

// File: tb/tb_vga_dither_out.sv
// tb_vga_dither_out: scoreboard bench for vga_dither_out with directed hand-computed vectors
module tb_vga_dither_out;
  localparam int   LAT = 2;
  localparam int   OB  = 2;
  localparam logic SRL = 1'b1;
  typedef struct packed {
    logic hs, vs, hb, vb;
    logic [7:0] r, g, b;
    logic [OB-1:0] rd, gd, bd;
  } exp_t;
  typedef struct {
    int    due;
    exp_t  e;
    string nm;
  } sb_t;
  sb_t  q[$];
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_hsync = 1'b0, in_vsync = 1'b0, in_hblank = 1'b0, in_vblank = 1'b0, dither_en = 1'b0;
  logic [1:0] in_hpos = '0, in_vpos = '0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic out_hsync, out_vsync, out_hblank, out_vblank;
  logic [7:0] out_r, out_g, out_b;
  logic [OB-1:0] out_rd, out_gd, out_bd;
  exp_t act, rst_e;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  logic [1:0] te [4];

  vga_dither_out #(.LATENCY(LAT), .OUT_BITS(OB), .SYNC_RESET_LEVEL(SRL)) dut (
    .clk(clk), .reset(reset),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblank(in_hblank), .in_vblank(in_vblank),
    .in_hpos(in_hpos), .in_vpos(in_vpos), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .dither_en(dither_en),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_hblank(out_hblank), .out_vblank(out_vblank),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_rd(out_rd), .out_gd(out_gd), .out_bd(out_bd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign act = {out_hsync, out_vsync, out_hblank, out_vblank, out_r, out_g, out_b, out_rd, out_gd, out_bd};

  initial begin
    sb_t s;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        s = q.pop_front();
        n_cmp++;
        if (act !== s.e) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %h want %h", s.nm, cyc, act, s.e);
        end
      end
    end
  end

  task automatic px(input string nm, input logic rs, input logic hs, input logic vs,
                    input logic hb, input logic vb, input logic [1:0] h, input logic [1:0] v,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic de,
                    input logic [OB-1:0] rd, input logic [OB-1:0] gd, input logic [OB-1:0] bd);
    exp_t e;
    @(negedge clk);
    reset = rs; in_hsync = hs; in_vsync = vs; in_hblank = hb; in_vblank = vb;
    in_hpos = h; in_vpos = v; in_r = r; in_g = g; in_b = b; dither_en = de;
    if (rs) begin
      foreach (q[i]) q[i].e = rst_e;
      e = rst_e;
    end else if (hb | vb) begin
      e = '0;
      e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    end else begin
      e = {hs, vs, hb, vb, r, g, b, rd, gd, bd};
    end
    q.push_back('{cyc + LAT, e, nm});
  endtask

  initial begin
    rst_e = '0;
    rst_e.hs = SRL;
    rst_e.vs = SRL;
`ifdef VGA_DITHER_TEMPORAL_EN
    te = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    te = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    repeat (3) px("reset", 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    px("dith_00", 0, 1, 0, 0, 0, 2'd0, 2'd0, 8'h30, 8'h00, 8'h00, 1, 2'd0, 2'd0, 2'd0);
    px("dith_10", 0, 0, 1, 0, 0, 2'd1, 2'd0, 8'h30, 8'h00, 8'h00, 1, 2'd1, 2'd0, 2'd0);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++)
        px("sat_ff", 0, h[0], v[0], 0, 0, 2'(h), 2'(v), 8'hFF, 8'hFF, 8'hFF, 1, 2'd3, 2'd3, 2'd3);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++)
        px("trunc_bf", 0, 1, 1, 0, 0, 2'(h), 2'(v), 8'h00, 8'hBF, 8'h00, 0, 2'd0, 2'd2, 2'd0);
    for (int i = 0; i < 12; i++)
      px("hblank", 0, 1, 1, (i >= 2 && i < 10), 0, 2'(i), 2'd0, 8'hFF, 8'h00, 8'h00, 1, 2'd3, 2'd0, 2'd0);
    repeat (2) px("pre_rst", 0, 0, 0, 0, 0, 0, 0, 8'h40, 8'h80, 8'hC0, 0, 2'd1, 2'd2, 2'd3);
    px("mid_rst", 1, 0, 0, 0, 0, 0, 0, 8'h40, 8'h80, 8'hC0, 0, 2'd1, 2'd2, 2'd3);
    repeat (3) px("post_rst", 0, 0, 0, 0, 0, 0, 0, 8'h55, 8'hAA, 8'hFF, 0, 2'd1, 2'd2, 2'd3);
    for (int f = 0; f < 4; f++) begin
      px("frame_px", 0, 1, 1, 0, 0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h30, 1, 2'd0, 2'd0, te[f]);
      px("vblank", 0, 1, 0, 0, 1, 2'd0, 2'd0, 8'h00, 8'h00, 8'h30, 1, 2'd0, 2'd0, 2'd0);
    end
    repeat (LAT + 3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
